// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter that shares one byte-wide UART
// transmitter between NUM_REQ producers. Each grant covers one whole frame.
// The transmitter reports no busy status, so a local timer marks the end of
// the frame.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int FRAME_CYCLES = 4800,
  parameter int IDW          = 2
) (
  input  logic                   clk,
  input  logic                   rst,        // asynchronous, active low
  input  logic                   en,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  output logic                   busy,
  output logic [IDW-1:0]         grant_id
);

  localparam int             TW         = $clog2(FRAME_CYCLES);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(FRAME_CYCLES - 1);
  localparam logic [IDW-1:0] PTR_RST    = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_LAUNCH = 2'd2,
    S_WAIT   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 busy_q, busy_d;
  logic [IDW-1:0]       grant_id_q, grant_id_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]        timer_q, timer_d;

  // Byte-lane view of the flat request data bus.
  logic [NUM_REQ-1:0][7:0] req_bytes;
  assign req_bytes = req_data;

  logic [IDW-1:0] win_id;
  logic           win_found;
  logic [IDW-1:0] cand;

  // Round-robin search: first valid requester after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_id    = cand;
        win_found = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic; every output comes from a flop.
  always_comb begin
    state_d     = state_q;
    req_ready_d = '0;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    busy_d      = busy_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    timer_d     = timer_q;
    case (state_q)
      S_IDLE: begin
        // Valid bits matter only here; en gates new grants only.
        if (en && win_found) begin
          tx_data_d           = req_bytes[win_id];
          grant_id_d          = win_id;
          rr_ptr_d            = win_id;
          req_ready_d[win_id] = 1'b1;
          busy_d              = 1'b1;
          state_d             = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        tx_start_d = 1'b1;
        state_d    = S_LAUNCH;
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Timer stops at its last value, so it never wraps.
        if (timer_q == TIMER_LAST) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= '0;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      grant_id_q  <= '0;
      rr_ptr_q    <= PTR_RST;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      timer_q     <= timer_d;
    end
  end

  assign req_ready = req_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;

endmodule
